// File: rtl/uart_ctrl_pkg.sv
// Shared definitions for the UART calculator link controllers:
// FSM state encodings and the byte-order codes used to pick tx_data.
package uart_ctrl_pkg;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_SEND_LSB  = 4'd1;
    localparam logic [3:0] ST_WAIT_LSB  = 4'd2;
    localparam logic [3:0] ST_DELAY_LSB = 4'd3;
    localparam logic [3:0] ST_SEND_MSB  = 4'd4;
    localparam logic [3:0] ST_WAIT_MSB  = 4'd5;
    localparam logic [3:0] ST_DELAY_MSB = 4'd6;
    localparam logic [3:0] ST_SEND_FLG  = 4'd7;
    localparam logic [3:0] ST_WAIT_FLG  = 4'd8;
    localparam logic [3:0] ST_DELAY_FLG = 4'd9;

    typedef enum logic [3:0] {
        S_IDLE      = ST_IDLE,
        S_SEND_LSB  = ST_SEND_LSB,
        S_WAIT_LSB  = ST_WAIT_LSB,
        S_DELAY_LSB = ST_DELAY_LSB,
        S_SEND_MSB  = ST_SEND_MSB,
        S_WAIT_MSB  = ST_WAIT_MSB,
        S_DELAY_MSB = ST_DELAY_MSB,
        S_SEND_FLG  = ST_SEND_FLG,
        S_WAIT_FLG  = ST_WAIT_FLG,
        S_DELAY_FLG = ST_DELAY_FLG
    } state_t;

    localparam logic [1:0] BYTE_LSB  = 2'd0;
    localparam logic [1:0] BYTE_MSB  = 2'd1;
    localparam logic [1:0] BYTE_FLG  = 2'd2;
    localparam logic [1:0] BYTE_NONE = 2'd3;

    // Which frame byte a state is working on; IDLE and unused codes select none.
    function automatic logic [1:0] state_byte(input logic [3:0] s);
        logic [1:0] b;
        case (s)
            ST_SEND_LSB, ST_WAIT_LSB, ST_DELAY_LSB: b = BYTE_LSB;
            ST_SEND_MSB, ST_WAIT_MSB, ST_DELAY_MSB: b = BYTE_MSB;
            ST_SEND_FLG, ST_WAIT_FLG, ST_DELAY_FLG: b = BYTE_FLG;
            default:                                b = BYTE_NONE;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_tx_result_ctrl_delay_timer.sv
// Down-counter for the inter-byte gap: load sets it to MAX, done marks the
// last cycle of the gap (count of 1), so a gap lasts exactly MAX cycles.
module delay_timer #(
    parameter int MAX = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic done
);

    localparam int W = $clog2(MAX + 1);
    localparam logic [W-1:0] CNT_MAX = W'(MAX);
    localparam logic [W-1:0] CNT_ONE = W'(1);

    logic [W-1:0] r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= CNT_MAX;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_ONE;
        end
    end

    assign done = (r_count == CNT_ONE);

endmodule

// File: rtl/uart_tx_result_ctrl.sv
// Captures an ALU result/flags on trigger and hands them to the UART TX core
// one byte at a time (LSB, MSB, optional flags) with a fixed gap between bytes.
module uart_tx_result_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int INTER_BYTE_DELAY = 1000000,
    parameter int SEND_FLAGS       = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        trigger,
    input  logic [15:0] result,
    input  logic [3:0]  flags,
    input  logic        tx_busy,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    output logic        busy,
    output logic [3:0]  stateID
);

    state_t      r_state;
    state_t      w_next_state;
    logic        w_capture;
    logic        w_load;
    logic        w_done;
    logic [15:0] r_res_q;
    logic [3:0]  r_flg_q;

    // Triggers outside IDLE are dropped, so the captured operands stay stable for the frame.
    assign w_capture = (r_state == S_IDLE) && trigger;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_res_q <= '0;
            r_flg_q <= '0;
        end else if (w_capture) begin
            r_res_q <= result;
            r_flg_q <= flags;
        end
    end

    delay_timer #(
        .MAX(INTER_BYTE_DELAY)
    ) u_delay_timer (
        .clock(clock),
        .reset(reset),
        .load (w_load),
        .done (w_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_IDLE;
        w_load       = 1'b0;
        case (r_state)
            S_IDLE:      w_next_state = trigger ? S_SEND_LSB : S_IDLE;
            S_SEND_LSB:  w_next_state = tx_busy ? S_WAIT_LSB : S_SEND_LSB;
            S_WAIT_LSB: begin
                w_load       = !tx_busy;
                w_next_state = tx_busy ? S_WAIT_LSB : S_DELAY_LSB;
            end
            S_DELAY_LSB: w_next_state = w_done ? S_SEND_MSB : S_DELAY_LSB;
            S_SEND_MSB:  w_next_state = tx_busy ? S_WAIT_MSB : S_SEND_MSB;
            S_WAIT_MSB: begin
                w_load       = !tx_busy;
                w_next_state = tx_busy ? S_WAIT_MSB : S_DELAY_MSB;
            end
            S_DELAY_MSB: begin
                if (!w_done) begin
                    w_next_state = S_DELAY_MSB;
                end else if (SEND_FLAGS != 0) begin
                    w_next_state = S_SEND_FLG;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_SEND_FLG:  w_next_state = tx_busy ? S_WAIT_FLG : S_SEND_FLG;
            S_WAIT_FLG: begin
                w_load       = !tx_busy;
                w_next_state = tx_busy ? S_WAIT_FLG : S_DELAY_FLG;
            end
            S_DELAY_FLG: w_next_state = w_done ? S_IDLE : S_DELAY_FLG;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tx_data = 8'h00;
        case (state_byte(r_state))
            BYTE_LSB: tx_data = r_res_q[7:0];
            BYTE_MSB: tx_data = r_res_q[15:8];
            BYTE_FLG: tx_data = {4'b0000, r_flg_q};
            default:  tx_data = 8'h00;
        endcase
    end

    assign tx_start = (r_state == S_SEND_LSB) || (r_state == S_SEND_MSB) ||
                      (r_state == S_SEND_FLG);
    assign busy     = (r_state != S_IDLE);
    assign stateID  = r_state;

endmodule

// File: tb/tb_uart_tx_result_ctrl.sv
// Bench: two controllers (3-byte and 2-byte framing) driven in lockstep, each
// with its own TX core model and a scoreboard monitor fed from the trigger log.
module tb_uart_tx_result_ctrl;

    localparam int D    = 4;
    localparam int HOLD = 10;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        trig   = 1'b0;
    logic [15:0] result = 16'h0000;
    logic [3:0]  flags  = 4'h0;
    int          lat    = 1;
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [19:0] trig_log[$];

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Frame byte order: result low byte, result high byte, zero-extended flags.
    function automatic int ref_byte(input logic [19:0] frm, input int pos);
        case (pos)
            0:       return int'(frm[7:0]);
            1:       return int'(frm[15:8]);
            default: return int'(frm[19:16]);
        endcase
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
        localparam int NB = (gi == 0) ? 3 : 2;
        logic       tx_busy = 1'b0;
        logic       tx_start;
        logic       busy;
        logic [7:0] tx_data;
        logic [3:0] sid;
        int         idx = 0;
        int         pos = 0;

        uart_tx_result_ctrl #(
            .INTER_BYTE_DELAY(D),
            .SEND_FLAGS      ((gi == 0) ? 1 : 0)
        ) u_dut (
            .clock   (clk),
            .reset   (rst),
            .trigger (trig),
            .result  (result),
            .flags   (flags),
            .tx_busy (tx_busy),
            .tx_start(tx_start),
            .tx_data (tx_data),
            .busy    (busy),
            .stateID (sid)
        );

        // TX core: busy rises lat cycles after start is seen, then holds HOLD cycles.
        initial begin : tx_model
            int pend;
            int hold;
            pend = 0;
            hold = 0;
            forever begin
                @(negedge clk);
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) tx_busy = 1'b0;
                end else if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        tx_busy = 1'b1;
                        hold    = HOLD;
                    end
                end else if (tx_start) begin
                    pend = lat;
                end
            end
        end

        initial begin : monitor
            int         gap;
            int         slen;
            bit         armed;
            logic       ps;
            logic       pb;
            logic [7:0] pd;
            logic [3:0] pst;
            gap = 0; slen = 0; armed = 1'b0; ps = 1'b0; pb = 1'b0; pd = 8'h00; pst = 4'h0;
            forever begin
                @(negedge clk);
                #1;
                if (rst) begin
                    if (pos != 0) idx++;
                    pos   = 0;
                    armed = 1'b0;
                    slen  = 0;
                end else begin
                    if (tx_start && tx_busy) begin
                        $display("lane%0d byte%0d data=0x%02h", gi, pos, tx_data);
                        if (idx >= trig_log.size()) begin
                            chk($sformatf("lane%0d_unexpected_byte", gi), 1, 0);
                        end else begin
                            chk($sformatf("lane%0d_frame%0d_byte%0d", gi, idx, pos),
                                int'(tx_data), ref_byte(trig_log[idx], pos));
                            pos++;
                            if (pos == NB) begin
                                pos = 0;
                                idx++;
                            end
                        end
                    end
                    if (tx_start && ps) chk($sformatf("lane%0d_data_stable", gi), int'(tx_data), int'(pd));
                    if (tx_start) slen++;
                    else if (ps) begin
                        chk($sformatf("lane%0d_start_len", gi), slen, lat + 1);
                        slen = 0;
                    end
                    if (!tx_busy && pb) begin
                        armed = (pos != 0);
                        gap   = 0;
                    end else if (armed && !tx_busy && !tx_start) begin
                        gap++;
                    end
                    if (tx_start && !ps && armed) begin
                        chk($sformatf("lane%0d_gap", gi), gap, D);
                        armed = 1'b0;
                    end
                    if (pst == 4'd6 && sid != 4'd6)
                        chk($sformatf("lane%0d_after_delay_msb", gi), int'(sid), (gi == 0) ? 7 : 0);
                    if (pst == 4'd9 && sid != 4'd9)
                        chk($sformatf("lane%0d_after_delay_flg", gi), int'(sid), 0);
                end
                ps  = tx_start;
                pb  = tx_busy;
                pd  = tx_data;
                pst = sid;
            end
        end
    end

    task automatic check_lanes_idle(input string tag);
        chk({tag, "_l0_state"}, int'(g_lane[0].sid), 0);
        chk({tag, "_l0_busy"},  int'(g_lane[0].busy), 0);
        chk({tag, "_l0_start"}, int'(g_lane[0].tx_start), 0);
        chk({tag, "_l0_data"},  int'(g_lane[0].tx_data), 0);
        chk({tag, "_l1_state"}, int'(g_lane[1].sid), 0);
        chk({tag, "_l1_busy"},  int'(g_lane[1].busy), 0);
        chk({tag, "_l1_start"}, int'(g_lane[1].tx_start), 0);
        chk({tag, "_l1_data"},  int'(g_lane[1].tx_data), 0);
    endtask

    task automatic send_frame(input logic [15:0] r, input logic [3:0] f, input bit log_it);
        @(negedge clk);
        result = r;
        flags  = f;
        trig   = 1'b1;
        if (log_it) trig_log.push_back({f, r});
        $display("trigger result=0x%04h flags=0x%0h lat=%0d", r, f, lat);
        @(negedge clk);
        trig = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 600 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (!g_lane[0].busy && !g_lane[1].busy && !g_lane[0].tx_busy && !g_lane[1].tx_busy)
                ok = 1'b1;
        end
        chk({tag, "_reaches_idle"}, int'(ok), 1);
    endtask

    task automatic wait_sid(input int v);
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 200 && !ok; c++) begin
            @(negedge clk);
            #1;
            if (int'(g_lane[0].sid) == v) ok = 1'b1;
        end
        if (!ok) chk("wait_state", int'(g_lane[0].sid), v);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [15:0] r;
        logic [3:0]  f;

        repeat (3) @(posedge clk);
        #1;
        check_lanes_idle("reset");
        chk("reset_res_q", int'(g_lane[0].u_dut.r_res_q), 0);
        chk("reset_flg_q", int'(g_lane[0].u_dut.r_flg_q), 0);
        @(negedge clk);
        rst = 1'b0;

        // Full frame and two-byte frame in parallel
        send_frame(16'hBEEF, 4'hA, 1'b1);
        wait_idle("full_frame");
        check_lanes_idle("full_frame_end");

        // Trigger while busy is ignored
        send_frame(16'hBEEF, 4'hA, 1'b1);
        wait_sid(5);
        result = 16'h5555;
        flags  = 4'h5;
        trig   = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        wait_idle("trig_busy");
        chk("trig_busy_l0_res_q", int'(g_lane[0].u_dut.r_res_q), 16'hBEEF);
        chk("trig_busy_l1_res_q", int'(g_lane[1].u_dut.r_res_q), 16'hBEEF);
        chk("trig_busy_l0_flg_q", int'(g_lane[0].u_dut.r_flg_q), 4'hA);

        // Slow core
        lat = 5;
        send_frame(16'hBEEF, 4'hA, 1'b1);
        wait_idle("slow_core");
        lat = 1;

        // Reset mid-frame, then a fresh frame
        send_frame(16'hBEEF, 4'hA, 1'b1);
        wait_sid(3);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_lanes_idle("mid_reset");
        @(negedge clk);
        rst = 1'b0;
        send_frame(16'h00FF, 4'h3, 1'b1);
        wait_idle("after_reset");

        // Trigger and reset in the same cycle
        @(negedge clk);
        rst    = 1'b1;
        trig   = 1'b1;
        result = 16'h5A5A;
        flags  = 4'h5;
        @(posedge clk);
        #1;
        chk("trig_rst_l0_state", int'(g_lane[0].sid), 0);
        chk("trig_rst_l0_res_q", int'(g_lane[0].u_dut.r_res_q), 0);
        chk("trig_rst_l1_res_q", int'(g_lane[1].u_dut.r_res_q), 0);
        chk("trig_rst_l0_flg_q", int'(g_lane[0].u_dut.r_flg_q), 0);
        @(negedge clk);
        rst  = 1'b0;
        trig = 1'b0;
        @(posedge clk);
        #1;
        chk("trig_rst_l0_state_after", int'(g_lane[0].sid), 0);

        // Randomized frames with varying core latency
        for (int n = 0; n < 6; n++) begin
            lat = $urandom_range(1, 4);
            r   = 16'($urandom);
            f   = 4'($urandom);
            send_frame(r, f, 1'b1);
            wait_idle($sformatf("rand%0d", n));
        end
        lat = 1;

        repeat (5) @(negedge clk);
        chk("l0_frames_done", g_lane[0].idx, trig_log.size());
        chk("l1_frames_done", g_lane[1].idx, trig_log.size());
        chk("l0_no_partial", g_lane[0].pos, 0);
        chk("l1_no_partial", g_lane[1].pos, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_result_ctrl.md
# uart_tx_result_ctrl

Transmit-side controller for the UART calculator link. It captures a 16-bit ALU result and 4-bit flags on a one-cycle `trigger`, then feeds them byte by byte to the UART transmitter core: result LSB, result MSB, then an optional flags byte. Consecutive bytes are separated by a programmable gap. It sits between the ALU result path and the UART TX core, mirroring the receive-side controller that assembles operands and issues the trigger.

## Interface
- `INTER_BYTE_DELAY`, default 1000000: idle clock cycles inserted after each byte completes. Legal range is >= 1.
- `SEND_FLAGS`, default 1: 1 sends 3 bytes (LSB, MSB, flags); 0 sends 2 bytes (LSB, MSB).
- `clock`  in  1  system clock.
- `reset`  in  1  reset, synchronous, active-high.
- `trigger`  in  1  one-cycle pulse requesting transmission of `result`/`flags`.
- `result`  in  16  ALU result, sampled on trigger.
- `flags`  in  4  ALU flags, sampled on trigger.
- `tx_busy`  in  1  UART TX core busy; high while a byte is shifting out.
- `tx_start`  out  1  send request to the TX core, level-held until `tx_busy` is seen high.
- `tx_data`  out  8  byte presented to the TX core.
- `busy`  out  1  high in every state except IDLE.
- `stateID`  out  4  current state encoding, for LEDs/debug.

## Operation
- State encodings:
  - 0 IDLE
  - 1 SEND_LSB, 2 WAIT_LSB, 3 DELAY_LSB
  - 4 SEND_MSB, 5 WAIT_MSB, 6 DELAY_MSB
  - 7 SEND_FLG, 8 WAIT_FLG, 9 DELAY_FLG
  - 10–15 unused; any of them returns to IDLE on the next edge.
- IDLE:
  - On `trigger`=1, latch `result` into `res_q` and `flags` into `flg_q`, then go to SEND_LSB.
  - Otherwise stay in IDLE; `res_q`/`flg_q` are unchanged.
- SEND_x: `tx_start`=1. Go to WAIT_x on the first cycle `tx_busy`=1; otherwise stay.
- WAIT_x: `tx_start`=0. On `tx_busy`=0, load the delay counter with `INTER_BYTE_DELAY` and go to DELAY_x.
- DELAY_x: decrement the counter each cycle; on the cycle the count reaches 1, leave:
  - DELAY_LSB → SEND_MSB.
  - DELAY_MSB → SEND_FLG if `SEND_FLAGS`=1, else IDLE.
  - DELAY_FLG → IDLE.
- `tx_data` is combinational from state:
  - LSB states: `res_q[7:0]`.
  - MSB states: `res_q[15:8]`.
  - FLG states: `{4'b0000, flg_q}`.
  - IDLE: 8'h00.
- `trigger` while `busy`=1 is ignored: no relatch, no queueing.
- Trigger and reset in the same cycle: reset wins.
- Reset mid-frame:
  - Next edge returns to IDLE.
  - `tx_start` drops; the partial frame is abandoned.
  - The TX core finishes any byte already in flight on its own.

## Timing
- Reset values:
  - state IDLE; `stateID`=0.
  - `busy`=0, `tx_start`=0, `tx_data`=8'h00.
  - `res_q`=0, `flg_q`=0, delay counter 0.
- Trigger sampled at edge N → SEND_LSB during cycle N+1: `tx_start`=1, `tx_data`=`res_q[7:0]`, `busy`=1.
- `tx_start` remains high, with `tx_data` stable, through the cycle in which `tx_busy` is first sampled high.
- Each DELAY_x state lasts exactly `INTER_BYTE_DELAY` cycles.
- `tx_busy` already high on entry to SEND_x (core still finishing a previous byte) → SEND_x exits after one cycle. The core must not accept a start while busy.
- Counter width is `$clog2(INTER_BYTE_DELAY+1)` bits, unsigned; no wrap occurs in legal use.

## Structure
- Shared package `uart_ctrl_pkg` holds:
  - The 4-bit state localparams above.
  - Byte-order constants: `BYTE_LSB`, `BYTE_MSB`, `BYTE_FLG`.
- One sub-module, `delay_timer #(MAX)`:
  - Inputs: `clock`, `reset`, `load`.
  - Output: `done`.
  - Counts down from `MAX`; `done` is high on the final cycle.
- Result and flags capture uses the existing 8-bit/parametric enable-register style, with the enable driven by IDLE & `trigger`.

## Test plan
Common bench setup: `INTER_BYTE_DELAY`=4. TX model raises `tx_busy` 1 cycle after `tx_start` and holds it 10 cycles.

- **Full frame.** Reset, then `trigger` with `result`=16'hBEEF, `flags`=4'hA → bytes 8'hEF, 8'hBE, 8'h0A in order. Each `tx_start` rises exactly 4 cycles after the prior `tx_busy` falls. Then IDLE, `busy`=0.
- **Two-byte mode.** `SEND_FLAGS`=0, `result`=16'h1234 → bytes 8'h34, 8'h12 only. `stateID` goes 6→0 after the second delay.
- **Trigger while busy.** Second `trigger` with 16'h5555 during WAIT_MSB → frame still sends 8'hEF, 8'hBE, 8'h0A. No fourth byte; `res_q` unchanged.
- **Slow core.** TX model delays `tx_busy` by 5 cycles → `tx_start` stays high for 6 cycles with `tx_data`=8'hEF stable. Exactly one byte is sent.
- **Reset mid-frame.** Reset asserted in DELAY_LSB → next cycle `stateID`=0, `tx_start`=0, `tx_data`=8'h00, `busy`=0. A new trigger with 16'h00FF sends 8'hFF first.
- **Trigger and reset together.** `trigger` and `reset` asserted in the same cycle → state stays IDLE, `res_q`=0.
